regfile_sb: RTL

//   Parametrised multi-read-port integer register file with a per-register

---
 rtl/rf_pkg.sv | 32 +++
 rtl/regfile_rd_port.sv | 62 ++++++
 rtl/regfile_sb.sv | 86 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
//
// Contents: default geometry, the hardwired-zero register index, and a
// ceil(log2) helper used to size register address fields.
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int NRD_DEFAULT   = 2;

  // Register 0 reads as zero, ignores writes and is never busy.
  localparam int ZERO_REG = 0;

  // ceil(log2(value)), minimum 1 so a 2-entry file still gets a 1-bit index.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file: array mux, zero force, bypass, busy select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the port answers every address every cycle.
//
// Ports:
//   regs     in   NREGS x XLEN  stored register contents
//   busy_vec in   NREGS         stored scoreboard bits
//   rst      in   1             reset in progress (suppresses bypass)
//   write    in   1             writeback enable this cycle
//   wraddr   in   AW            writeback index
//   wrdata   in   XLEN          writeback data
//   rdaddr   in   AW            index read by this port
//   rddata   out  XLEN          data seen by this port
//   busy     out  1             scoreboard bit seen by this port
module regfile_rd_port
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int AW     = clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [NREGS-1:0]           busy_vec,
  input  logic                       rst,
  input  logic                       write,
  input  logic [AW-1:0]              wraddr,
  input  logic [XLEN-1:0]            wrdata,
  input  logic [AW-1:0]              rdaddr,
  output logic [XLEN-1:0]            rddata,
  output logic                       busy
);

  logic is_zero;
  logic bypass_hit;

  always_comb begin
    is_zero = (rdaddr == AW'(ZERO_REG));

    // A retiring write to the address being read is forwarded, and since the
    // producer is retiring the register is no longer busy for the reader.
    // The bypass is off during reset because that edge discards the write.
    bypass_hit = (BYPASS != 0) && write && !rst &&
                 (wraddr != AW'(ZERO_REG)) && (wraddr == rdaddr);
  end

  always_comb begin
    rddata = regs[rdaddr];
    busy   = busy_vec[rdaddr];
    if (bypass_hit) begin
      rddata = wrdata;
      busy   = 1'b0;
    end
    // Storage for register 0 is never written, but force it here as well so
    // the port is correct on its own and the zero read is obvious.
    if (is_zero) begin
      rddata = '0;
      busy   = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard for hazard detection.
// Latency: reads 0 cycles (optional same-cycle write bypass); write and mark take effect at the next clk edge.
// Backpressure: none; write, mark and reads are accepted every cycle.
//
// Ports:
//   clk      in   1         rising-edge clock
//   rst      in   1         synchronous active-high reset (clears data and busy)
//   write    in   1         writeback enable
//   wraddr   in   AW        writeback register index
//   wrdata   in   XLEN      writeback data
//   rdaddr   in   NRD*AW    read indices, port i at [i*AW +: AW]
//   rddata   out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   mark     in   1         issue: set busy bit of markaddr at the next edge
//   markaddr in   AW        destination register being issued
//   busy     out  NRD       scoreboard bit for each read port's address
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = NRD_DEFAULT,
  parameter int BYPASS = 1,
  localparam int AW    = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic [AW-1:0]       wraddr,
  input  logic [XLEN-1:0]     wrdata,
  input  logic [NRD*AW-1:0]   rdaddr,
  output logic [NRD*XLEN-1:0] rddata,
  input  logic                mark,
  input  logic [AW-1:0]       markaddr,
  output logic [NRD-1:0]      busy
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy_q;

  logic wr_en;
  logic mark_en;

  // Register 0 is filtered out here, so its storage and busy bit stay at
  // their reset value of zero forever.
  always_comb begin
    wr_en   = write && (wraddr   != AW'(ZERO_REG));
    mark_en = mark  && (markaddr != AW'(ZERO_REG));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[wraddr] <= wrdata;
        busy_q[wraddr] <= 1'b0;
      end
      // Ordered after the write: when a new producer issues to the register
      // that is retiring this cycle, the new producer keeps it busy.
      if (mark_en) begin
        busy_q[markaddr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd (
      .regs     (regs_q),
      .busy_vec (busy_q),
      .rst      (rst),
      .write    (write),
      .wraddr   (wraddr),
      .wrdata   (wrdata),
      .rdaddr   (rdaddr[i*AW +: AW]),
      .rddata   (rddata[i*XLEN +: XLEN]),
      .busy     (busy[i])
    );
  end

endmodule
